// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and per-result status flags.
// Optional feature macro: ALU_MUL_EN builds the iterative shift-add multiplier (opcode 1000).

module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             OpErr
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic op_err;
    } flags_t;

`ifdef ALU_MUL_EN
    localparam logic [3:0]     OP_MUL   = 4'b1000;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
    typedef enum logic {S_IDLE, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic             accept;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_sum;
    logic [SHW-1:0]   cnt_q, cnt_d;

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    assign shamt   = B[SHW-1:0];
    assign sum_ext = {1'b0, A} + {1'b0, B};
    // Top bit of the widened difference is the borrow; Carry reports its inverse.
    assign dif_ext = {1'b0, A} - {1'b0, B};

    function automatic flags_t make_flags(input logic [WIDTH-1:0] res, input logic c,
                                          input logic v, input logic e);
        flags_t f;
        f.zero     = (res == '0);
        f.negative = res[WIDTH-1];
        f.carry    = c;
        f.overflow = v;
        f.op_err   = e;
        return f;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = dif_ext[WIDTH-1:0];
                alu_carry = ~dif_ext[WIDTH];
                alu_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL: alu_res = A << shamt;
            OP_SRL: alu_res = A >> shamt;
            default: alu_err = 1'b1;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // A new accept in DONE replaces the pending result on the same edge.
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (ALUControl == OP_MUL) begin
                        state_d  = S_BUSY;
                        mcand_d  = A;
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else
`endif
                    begin
                        state_d  = S_DONE;
                        result_d = alu_res;
                        flags_d  = make_flags(alu_res, alu_carry, alu_ovf, alu_err);
                    end
                end else if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            S_BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    result_d = acc_sum;
                    flags_d  = make_flags(acc_sum, 1'b0, 1'b0, 1'b0);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign Result   = result_q;
    assign Zero     = flags_q.zero;
    assign Negative = flags_q.negative;
    assign Carry    = flags_q.carry;
    assign Overflow = flags_q.overflow;
    assign OpErr    = flags_q.op_err;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected responses, a monitor pops on handshake.
// MUL tests are built when ALU_MUL_EN is defined; otherwise opcode 1000 is checked as unsupported.

module tb_alu_seq;

    localparam int W = 32;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [4:0]   fl;   // {Zero, Negative, Carry, Overflow, OpErr}
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   ALUControl;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;
    logic         Zero, Negative, Carry, Overflow, OpErr;
    logic [W+4:0] dut_resp;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W+4:0] exp_q[$];
    vec_t         vecs[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Zero       (Zero),
        .Negative   (Negative),
        .Carry      (Carry),
        .Overflow   (Overflow),
        .OpErr      (OpErr)
    );

    assign dut_resp = {Result, Zero, Negative, Carry, Overflow, OpErr};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res, input logic [4:0] fl);
        vec_t v;
        v.op  = op;
        v.a   = a;
        v.b   = b;
        v.res = res;
        v.fl  = fl;
        vecs.push_back(v);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] res, input logic [4:0] fl,
                        input bit push, input bit single, output int waits);
        int w   = 0;
        bit rdy = 1'b0;
        ALUControl = op;
        A          = a;
        B          = b;
        in_valid   = 1'b1;
        if (push) exp_q.push_back({res, fl});
        while (!rdy && w < 100) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (!rdy) w++;
        end
        in_valid = 1'b0;
        A        = ~a;
        B        = ~b;
        waits    = w;
        if (!rdy) check({name, "_accept_timeout"}, 64'd0, 64'd1);
        else if (single) check({name, "_latency"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  waits;
        int  total_waits;
        bit  bad;
        bit  seen;

        reset      = 1'b1;
        in_valid   = 1'b1;
        ALUControl = 4'b0000;
        A          = 32'd1;
        B          = 32'd2;
        out_ready  = 1'b1;

        fork
            forever begin
                logic [W+4:0] e;
                @(negedge clk);
                if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected: got %h expected no output", dut_resp);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_resp", 64'(dut_resp), 64'(e));
                    end
                end
            end
        join_none

        // Reset held three cycles with an operation presented: nothing accepted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_state", {out_valid, dut_resp}, '0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("reset_no_accept", 64'(out_valid), 64'd0);

        add_vec(4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010);
        add_vec(4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 5'b10100);
        add_vec(4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b01000);
        add_vec(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100);
        add_vec(4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00110);
        add_vec(4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 5'b00000);
        add_vec(4'b0011, 32'h80000000, 32'h00000001, 32'h80000001, 5'b01000);
        add_vec(4'b0100, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 5'b00000);
        add_vec(4'b0101, 32'h80000000, 32'h00000001, 32'h00000001, 5'b00000);
        add_vec(4'b0101, 32'h00000001, 32'h80000000, 32'h00000000, 5'b10000);
        add_vec(4'b0101, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 5'b10000);
        add_vec(4'b0110, 32'h00000001, 32'h00000024, 32'h00000010, 5'b00000);
        add_vec(4'b0111, 32'h80000000, 32'h0000001F, 32'h00000001, 5'b00000);
        add_vec(4'b0110, 32'h12345678, 32'h00000000, 32'h12345678, 5'b00000);
        add_vec(4'b0111, 32'hF0000000, 32'h00000020, 32'hF0000000, 5'b01000);
        add_vec(4'b0110, 32'h00000001, 32'h0000001F, 32'h80000000, 5'b01000);
        add_vec(4'b1111, 32'h00000005, 32'h00000003, 32'h00000000, 5'b10001);
        add_vec(4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10001);
`ifndef ALU_MUL_EN
        add_vec(4'b1000, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 5'b10001);
`endif

        total_waits = 0;
        foreach (vecs[i]) begin
            send($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                 vecs[i].fl, 1'b1, 1'b1, waits);
            total_waits += waits;
        end
        check("throughput_stalls", 64'(total_waits), 64'd0);

        // Let the last vector drain, then hold a result under back-pressure.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send("bp_add", 4'b0000, 32'd1, 32'd2, 32'd3, 5'b00000, 1'b1, 1'b1, waits);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 64'({out_valid, dut_resp}), 64'({1'b1, 32'd3, 5'b00000}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send("b2b_add", 4'b0000, 32'd10, 32'd20, 32'd30, 5'b00000, 1'b1, 1'b1, waits);
        check("b2b_no_stall", 64'(waits), 64'd0);
        check("b2b_result", 64'(dut_resp), 64'({32'd30, 5'b00000}));

`ifdef ALU_MUL_EN
        send("mul_ffff", 4'b1000, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 5'b01000,
             1'b1, 1'b0, waits);
        bad = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        check("mul_busy_window", 64'(bad), 64'd0);
        check("mul_latency", 64'(out_valid), 64'd1);

        send("mul_3x5", 4'b1000, 32'd3, 32'd5, 32'd15, 5'b00000, 1'b1, 1'b0, waits);
        send("mul_wrap", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5'b00000,
             1'b1, 1'b0, waits);
        send("mul_zero", 4'b1000, 32'd7, 32'd0, 32'd0, 5'b10000, 1'b1, 1'b0, waits);

        // Abandon a multiply with a one-cycle reset on the tenth busy cycle.
        send("mul_abort", 4'b1000, 32'd2, 32'd3, 32'd6, 5'b00000, 1'b0, 1'b0, waits);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mul_abort_idle", 64'({out_valid, in_ready}), 64'b01);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("mul_abort_no_output", 64'(seen), 64'd0);
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshake-driven successor to the team's combinational 32-bit ALU. It is parametrised in data width and adds an opcode bit with XOR, shift and iterative multiply operations. Each result carries status flags. It sits between the decode/operand-fetch stage and writeback of the multi-cycle datapath, and either side may stall it through a valid/ready handshake on each end.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept operation this cycle
- ALUControl  in  4  opcode
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- out_valid  out  1  Result/flags valid
- out_ready  in  1  consumer takes result this cycle
- Result  out  WIDTH  registered result
- Zero, Negative, Carry, Overflow  out  1 each  registered flags
- OpErr  out  1  registered; opcode unsupported

## Operation
- Opcodes:
  - 0000 ADD; 0001 SUB (A-B); 0010 AND; 0011 OR; 0100 XOR
  - 0101 SLT (signed, Result=1 if A<B, correct under overflow)
  - 0110 SLL; 0111 SRL (logical; amount = B[SHW-1:0], upper B bits ignored)
  - 1000 MUL (low WIDTH bits of A*B, unsigned shift-add, one bit per cycle)
  - 1001..1111 unsupported: Result=0, OpErr=1
- Flags:
  - Zero = (Result==0); Negative = Result[WIDTH-1]
  - Carry = carry-out for ADD; for SUB, Carry = no-borrow (A>=B unsigned); 0 otherwise
  - Overflow = signed overflow for ADD/SUB; 0 otherwise
  - Zero/Negative apply to every op, including unsupported ones (Zero=1)
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On accept (in_valid&in_ready):
    - MUL → BUSY, latching A, B and clearing the accumulator and counter
    - any other op → DONE, with Result/flags registered
  - BUSY: in_ready=0. Each cycle: if multiplier LSB is set, add the shifted multiplicand into the accumulator; shift; counter+1. After WIDTH iterations → DONE.
  - DONE: out_valid=1; Result/flags held stable until out_ready=1.
    - out_ready=1 with no new accept → IDLE
    - in_ready = out_ready (combinational), so back-to-back accept is allowed. A simultaneous accept behaves as an IDLE accept: → DONE or BUSY, with the new result replacing the old on the same edge.
- Operands are sampled only on the accept edge; input changes afterwards have no effect.

## Timing
- Reset values: state=IDLE, in_ready=1 (after the reset edge), out_valid=0, Result=0, Zero=0, Negative=0, Carry=0, Overflow=0, OpErr=0, counter/accumulator=0.
- reset=1 during in_ready is don't-care for acceptance: reset wins and no operation is accepted.
- Non-MUL latency: accept on edge k → out_valid=1 after edge k; sustained throughput is 1 op/cycle while out_ready=1.
- MUL latency: accept on edge k → out_valid=1 after edge k+WIDTH; in_ready=0 for WIDTH cycles.
- Back-pressure: with out_ready=0 in DONE, out_valid, Result and flags remain constant indefinitely.
- Reset mid-BUSY or mid-DONE abandons the operation; the result is never presented.
- Shift by 0 returns A unchanged; SLL/SRL by WIDTH-1 are legal. MUL results wrap modulo 2^WIDTH.

## Configuration
- ALU_MUL_EN defined:
  - opcode 1000 is a multi-cycle MUL as above; BUSY state and counter/accumulator present
- ALU_MUL_EN undefined:
  - BUSY logic is not built
  - 1000 is unsupported: single-cycle, Result=0, Zero=1, OpErr=1
  - FSM uses IDLE/DONE only

## Test plan
- Reset: hold reset 3 cycles with in_valid=1 → out_valid=0, Result=0, all flags 0; in_ready=1 after release.
- ADD/SUB flags (WIDTH=32):
  - ADD 7FFFFFFF+00000001 → 80000000, Overflow=1, Negative=1, Carry=0
  - SUB 00000005-00000005 → 0, Zero=1, Carry=1
  - SUB 00000000-00000001 → FFFFFFFF, Carry=0
- SLT/shift:
  - SLT 80000000 vs 00000001 → 1
  - SLT 00000001 vs 80000000 → 0
  - SLL 00000001 by B=00000024 (amount 4) → 00000010
  - SRL 80000000 by 31 → 00000001
- MUL (ALU_MUL_EN): 0000FFFF*0000FFFF → FFFE0001
  - out_valid exactly 32 cycles after accept; in_ready=0 throughout
  - reset asserted at cycle 10 → out_valid never rises; IDLE next cycle
- Back-pressure/back-to-back:
  - out_ready=0 for 5 cycles → Result stable
  - then out_ready=1 with a new ADD presented → accepted on the same edge; next Result is the new sum, no bubble
- Unsupported: ALUControl=1111 (and 1000 without ALU_MUL_EN) → Result=0, Zero=1, OpErr=1, one-cycle latency.
